posit32_decode_pipe: RTL and testbench
======================================

POSIT32_DECODE_PIPE -- requirements
Module: posit32_decode_pipe

Interface
REQ-001 SHALL have parameter ES, default 2, meaning exponent field width (fixed at 2 for posit32 standard; other values out of scope).
REQ-002 SHALL have ports, in order:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_posit valid
- in_ready  output  1  block accepts in_posit this cycle
- in_posit  input  32  raw posit32 word
- out_valid  output  1  decoded fields valid
- out_ready  input  1  consumer accepts outputs this cycle
- out_sign  output  1  sign bit
- out_zero  output  1  input was 0x0000_0000
- out_nar  output  1  input was 0x8000_0000 (NaR)
- out_scale  output  9  signed scale = k*4 + e
- out_frac  output  27  fraction, MSB-aligned, hidden bit not included, zero-padded

Function
REQ-003 SHALL be a 2-stage valid/ready pipeline; a transfer occurs on any edge where valid and ready are both high.
REQ-004 Stage 1 SHALL register sign = p[31], zero/NaR flags, and magnitude body = sign ? (-p mod 2^32) : p.
REQ-005 Stage 2 SHALL take v = body[30:0], compute run length m of bits equal to v[30] counted from bit 30 downward (1..31), and register all outputs.
REQ-006 SHALL set k = m-1 when v[30]=1, k = -m when v[30]=0.
REQ-007 Bits below the regime terminator SHALL supply e (ES bits, MSB first), then the fraction; missing bits SHALL read as 0.
REQ-008 When m = 31, no terminator, exponent or fraction bits exist; e = 0 and out_frac = 0.
REQ-009 For zero or NaR inputs, out_scale and out_frac SHALL be 0, out_sign SHALL equal p[31].
REQ-010 Latency SHALL be exactly 2 cycles from input transfer to out_valid when out_ready stays high; throughput 1 word/cycle.
REQ-011 Each stage SHALL advance when it is empty or its downstream consumer accepts in the same cycle.
REQ-012 in_ready SHALL be high when stage 1 is empty, or stage 1 moves to stage 2 in the same cycle; it may depend combinationally on out_ready.
REQ-013 When out_valid=1 and out_ready=0, all out_* SHALL hold stable until accepted.
REQ-014 With both stages full and out_ready low, in_ready SHALL be 0 and no word SHALL be lost or duplicated.
REQ-015 Simultaneous output accept and input accept with full pipeline SHALL shift both stages in the same cycle with no bubble.
REQ-016 Order of words SHALL be preserved.

Reset
REQ-017 While rst_n=0, both stage valids SHALL be 0, out_valid=0, and all out_* data = 0, independent of clk.
REQ-018 Reset asserted mid-operation SHALL discard in-flight words; the first post-reset output SHALL be the first word accepted after deassertion.
REQ-019 in_ready SHALL be 1 in the first cycle after reset release.

Verification
REQ-020 in 0x4000_0000, out_ready=1 -> after 2 cycles: sign 0, scale 0, frac 0, zero 0, nar 0 (1.0).
REQ-021 in 0x4C00_0000 -> scale 1, frac 0x400_0000 (3.0); in 0xC000_0000 -> sign 1, scale 0, frac 0 (-1.0).
REQ-022 in 0x0000_0001 -> scale -120 (0x188), frac 0; in 0x7FFF_FFFF -> scale 120, frac 0.
REQ-023 in 0x0000_0000 -> zero 1, scale 0; in 0x8000_0000 -> nar 1, sign 1, scale 0, frac 0.
REQ-024 Stream 0x4000_0000, 0x4800_0000, 0x4C00_0000 with out_ready=0 for 4 cycles -> in_ready drops after 2 accepts, outputs hold the first word; on release outputs scale 0, 1, 1 in order with no loss.
REQ-025 Assert rst_n=0 with 2 words in flight, release, send 0x4800_0000 -> only scale 1 emerges, 2 cycles after acceptance.

Source files
------------

// File: rtl/posit32_decode_pipe.sv
// posit32_decode_pipe: two-stage valid/ready decoder that splits a posit32
// word into sign, zero/NaR flags, signed scale (k*2^ES + e) and a
// left-aligned fraction with the hidden bit removed.
module posit32_decode_pipe #(
    parameter int unsigned ES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_posit,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sign,
    output logic        out_zero,
    output logic        out_nar,
    output logic [8:0]  out_scale,
    output logic [26:0] out_frac
);
    localparam int unsigned FW = 27;

    // Stage 1 registers
    logic        r_s1_valid;
    logic        r_s1_sign;
    logic        r_s1_zero;
    logic        r_s1_nar;
    logic [30:0] r_s1_body;

    // Stage 2 (output) registers
    logic        r_s2_valid;
    logic        r_s2_sign;
    logic        r_s2_zero;
    logic        r_s2_nar;
    logic [8:0]  r_s2_scale;
    logic [26:0] r_s2_frac;

    // Handshake and decode wires
    logic              w_s2_ready;
    logic              w_in_ready;
    logic [30:0]       w_mag;
    logic [30:0]       w_x;
    logic [4:0]        w_m;
    logic              w_found;
    logic [4:0]        w_shamt;
    logic [ES+FW-1:0]  w_rem;
    logic [ES-1:0]     w_e;
    logic [FW-1:0]     w_frac;
    logic [8:0]        w_k;
    logic [8:0]        w_scale;

    assign w_s2_ready = !r_s2_valid || out_ready;
    assign w_in_ready = !r_s1_valid || w_s2_ready;
    assign in_ready   = w_in_ready;

    // Only the low 31 bits of the two's-complement magnitude are needed;
    // bit 31 is nonzero only for NaR, which is flagged separately.
    assign w_mag = in_posit[31] ? (31'd0 - in_posit[30:0]) : in_posit[30:0];

    // Stage 1: capture sign, special-value flags and magnitude body
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_zero  <= 1'b0;
            r_s1_nar   <= 1'b0;
            r_s1_body  <= '0;
        end else if (w_in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sign <= in_posit[31];
                r_s1_zero <= (in_posit == 32'h0000_0000);
                r_s1_nar  <= (in_posit == 32'h8000_0000);
                r_s1_body <= w_mag;
            end
        end
    end

    // Regime run length: leading zeros of the body with its top bit folded to 0
    always_comb begin
        w_x     = r_s1_body[30] ? ~r_s1_body : r_s1_body;
        w_m     = 5'd31;
        w_found = 1'b0;
        for (int unsigned i = 0; i < 31; i++) begin
            if (!w_found && w_x[30 - i]) begin
                w_m     = 5'(i);
                w_found = 1'b1;
            end
        end
    end

    // Strip regime and terminator; bits shifted past the end read as zero.
    // The m regime bits plus terminator cover bits 30..29 at minimum, so the
    // tail is taken from bit 28 shifted by m-1.
    always_comb begin
        w_shamt = w_m - 5'd1;
        w_rem   = r_s1_body[ES+FW-1:0] << w_shamt;
        w_e     = w_rem[ES+FW-1 -: ES];
        w_frac  = w_rem[FW-1:0];
        w_k     = r_s1_body[30] ? ({4'd0, w_m} - 9'd1) : (9'd0 - {4'd0, w_m});
        w_scale = 9'(w_k << ES) + 9'(w_e);
    end

    // Stage 2: register decoded fields, holding them while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_sign  <= 1'b0;
            r_s2_zero  <= 1'b0;
            r_s2_nar   <= 1'b0;
            r_s2_scale <= '0;
            r_s2_frac  <= '0;
        end else if (w_s2_ready) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_sign <= r_s1_sign;
                r_s2_zero <= r_s1_zero;
                r_s2_nar  <= r_s1_nar;
                if (r_s1_zero || r_s1_nar) begin
                    r_s2_scale <= '0;
                    r_s2_frac  <= '0;
                end else begin
                    r_s2_scale <= w_scale;
                    r_s2_frac  <= w_frac;
                end
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_sign  = r_s2_sign;
    assign out_zero  = r_s2_zero;
    assign out_nar   = r_s2_nar;
    assign out_scale = r_s2_scale;
    assign out_frac  = r_s2_frac;

endmodule

// File: tb/tb_posit32_decode_pipe.sv
// Scoreboard bench for posit32_decode_pipe with hand-decoded vectors.
module tb_posit32_decode_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_posit;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic        out_zero;
    logic        out_nar;
    logic [8:0]  out_scale;
    logic [26:0] out_frac;

    typedef struct {
        logic        sign;
        logic        zero;
        logic        nar;
        logic [8:0]  scale;
        logic [26:0] frac;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   n_checks = 0;
    int   n_err    = 0;
    int   n_out    = 0;
    int   cyc      = 0;
    bit   stop_tog = 1'b0;

    posit32_decode_pipe #(.ES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_posit  (in_posit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_zero  (out_zero),
        .out_nar   (out_nar),
        .out_scale (out_scale),
        .out_frac  (out_frac)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic s, input logic z, input logic n,
                                input logic [8:0] sc, input logic [26:0] f, input bit lat);
        exp_t e;
        e.sign  = s;
        e.zero  = z;
        e.nar   = n;
        e.scale = sc;
        e.frac  = f;
        e.acc   = 0;
        e.lat   = lat;
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the transfer edge.
    task automatic send(input logic [31:0] p, input exp_t e);
        int unsigned n = 0;
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_posit = p;
        while (!ok && n < 100) begin
            @(negedge clk);
            n++;
            if (in_ready) ok = 1'b1;
        end
        if (ok) begin
            e.acc = cyc;
            sb.push_back(e);
        end else begin
            n_checks++;
            n_err++;
            $display("FAIL send_timeout: in_ready stayed 0, required 1 for %0h", p);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop and compare every accepted output word
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_out++;
            if (sb.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_output: got scale %0h frac %0h, required no output",
                         out_scale, out_frac);
            end else begin
                m_e = sb.pop_front();
                chk("out_sign",  64'(out_sign),  64'(m_e.sign));
                chk("out_zero",  64'(out_zero),  64'(m_e.zero));
                chk("out_nar",   64'(out_nar),   64'(m_e.nar));
                chk("out_scale", 64'(out_scale), 64'(m_e.scale));
                chk("out_frac",  64'(out_frac),  64'(m_e.frac));
                if (m_e.lat) chk("latency", 64'(cyc - m_e.acc), 64'd2);
            end
        end
    end

    initial begin
        int snap;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_posit  = '0;
        out_ready = 1'b1;

        // Reset state, before and after clock edges
        #1;
        chk("rst_out_valid_noclk", 64'(out_valid), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_scale", 64'(out_scale), 64'd0);
        chk("rst_out_frac",  64'(out_frac),  64'd0);
        chk("rst_out_flags", 64'({out_sign, out_zero, out_nar}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Directed vectors, back-to-back with out_ready high
        send(32'h4000_0000, mk(1'b0, 1'b0, 1'b0, 9'h000, 27'h0000000, 1'b1));
        send(32'h4C00_0000, mk(1'b0, 1'b0, 1'b0, 9'h001, 27'h4000000, 1'b1));
        send(32'hC000_0000, mk(1'b1, 1'b0, 1'b0, 9'h000, 27'h0000000, 1'b1));
        send(32'h0000_0001, mk(1'b0, 1'b0, 1'b0, 9'h188, 27'h0000000, 1'b1));
        send(32'h7FFF_FFFF, mk(1'b0, 1'b0, 1'b0, 9'h078, 27'h0000000, 1'b1));
        send(32'h0000_0000, mk(1'b0, 1'b1, 1'b0, 9'h000, 27'h0000000, 1'b1));
        send(32'h8000_0000, mk(1'b1, 1'b0, 1'b1, 9'h000, 27'h0000000, 1'b1));
        send(32'h4800_0000, mk(1'b0, 1'b0, 1'b0, 9'h001, 27'h0000000, 1'b1));
        send(32'h6000_0000, mk(1'b0, 1'b0, 1'b0, 9'h004, 27'h0000000, 1'b1));
        send(32'h2000_0000, mk(1'b0, 1'b0, 1'b0, 9'h1FC, 27'h0000000, 1'b1));
        send(32'h4A00_0000, mk(1'b0, 1'b0, 1'b0, 9'h001, 27'h2000000, 1'b1));
        send(32'hBC00_0000, mk(1'b1, 1'b0, 1'b0, 9'h000, 27'h4000000, 1'b1));
        send(32'h7FFF_FFFE, mk(1'b0, 1'b0, 1'b0, 9'h074, 27'h0000000, 1'b1));
        send(32'h0000_0003, mk(1'b0, 1'b0, 1'b0, 9'h18E, 27'h0000000, 1'b1));
        send(32'h7FFF_FFFD, mk(1'b0, 1'b0, 1'b0, 9'h072, 27'h0000000, 1'b1));
        drain();

        // Backpressure: two accepts fill the pipe, third word waits
        out_ready = 1'b0;
        send(32'h4000_0000, mk(1'b0, 1'b0, 1'b0, 9'h000, 27'h0000000, 1'b0));
        send(32'h4800_0000, mk(1'b0, 1'b0, 1'b0, 9'h001, 27'h0000000, 1'b0));
        in_valid = 1'b1;
        in_posit = 32'h4C00_0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_in_ready",  64'(in_ready),  64'd0);
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_out_scale", 64'(out_scale), 64'd0);
            chk("stall_out_frac",  64'(out_frac),  64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(32'h4C00_0000, mk(1'b0, 1'b0, 1'b0, 9'h001, 27'h4000000, 1'b0));
        drain();

        // Reset with two words in flight discards them
        out_ready = 1'b0;
        send(32'hC000_0000, mk(1'b1, 1'b0, 1'b0, 9'h000, 27'h0000000, 1'b0));
        send(32'h7FFF_FFFF, mk(1'b0, 1'b0, 1'b0, 9'h078, 27'h0000000, 1'b0));
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_out_sign",  64'(out_sign),  64'd0);
        chk("midrst_out_scale", 64'(out_scale), 64'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        snap = n_out;
        @(negedge clk);
        chk("in_ready_after_midrst", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        send(32'h4800_0000, mk(1'b0, 1'b0, 1'b0, 9'h001, 27'h0000000, 1'b1));
        drain();
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_output_count", 64'(n_out - snap), 64'd1);

        // Random out_ready toggling: order and values preserved
        stop_tog = 1'b0;
        fork
            begin
                while (!stop_tog) begin
                    @(posedge clk);
                    #1;
                    if (!stop_tog) out_ready = 1'($urandom_range(0, 1));
                end
            end
        join_none
        send(32'h4A00_0000, mk(1'b0, 1'b0, 1'b0, 9'h001, 27'h2000000, 1'b0));
        send(32'h2000_0000, mk(1'b0, 1'b0, 1'b0, 9'h1FC, 27'h0000000, 1'b0));
        send(32'h8000_0000, mk(1'b1, 1'b0, 1'b1, 9'h000, 27'h0000000, 1'b0));
        send(32'h6000_0000, mk(1'b0, 1'b0, 1'b0, 9'h004, 27'h0000000, 1'b0));
        send(32'hBC00_0000, mk(1'b1, 1'b0, 1'b0, 9'h000, 27'h4000000, 1'b0));
        send(32'h0000_0000, mk(1'b0, 1'b1, 1'b0, 9'h000, 27'h0000000, 1'b0));
        send(32'h0000_0003, mk(1'b0, 1'b0, 1'b0, 9'h18E, 27'h0000000, 1'b0));
        stop_tog = 1'b1;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
